dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: port 0, the RV32I core load/store path, and port 1, a debug/DMA loader used for image loads and result dumps.
- Sits between the core's DataAdr/WriteData/MemWrite outputs plus a debug master on one side, and the dmem array on the other.
- Fixed priority for the core, starvation guard for port 1, optional bus lock for port 1 bursts.
- Memory is synchronous with 1-cycle read latency.

---
 rtl/dmem_port_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single data-memory port: core (port 0) has
// priority, the debug/DMA master (port 1) gets a starvation guard and a bus lock.
module dmem_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [3:0]    p0_wstrb,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic [3:0]    p1_wstrb,
  input  logic          p1_lock,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [1:0]    rd_pend_q, rd_pend_d;
  logic          gnt0, gnt1;

  // State, starvation counter and read-owner tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      starve_q  <= '0;
      rd_pend_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Grant decision; a LOCKED cycle with p1_lock low arbitrates exactly like ARB
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    if (state_q == LOCKED && p1_lock) begin
      gnt1     = p1_req;
      starve_d = '0;
    end else begin
      state_d = ARB;
      if (starve_q == WAIT_LIMIT && p1_req) begin
        gnt1 = 1'b1;
      end else if (p0_req) begin
        gnt0 = 1'b1;
      end else if (p1_req) begin
        gnt1 = 1'b1;
      end
      if (p1_req && !gnt1) begin
        starve_d = (starve_q == WAIT_LIMIT) ? starve_q : CW'(starve_q + 1'b1);
      end else begin
        starve_d = '0;
      end
      if (gnt1 && p1_lock) begin
        state_d = LOCKED;
      end
    end
    rd_pend_d = {gnt1 && !p1_we, gnt0 && !p0_we};
  end

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;

  // Memory port follows whichever requester holds the grant
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (gnt0) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      mem_wstrb = p0_wstrb;
    end else if (gnt1) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_wstrb = p1_wstrb;
    end
  end

  assign p0_rvalid = rd_pend_q[0];
  assign p1_rvalid = rd_pend_q[1];
  assign p0_rdata  = rd_pend_q[0] ? mem_rdata : '0;
  assign p1_rdata  = rd_pend_q[1] ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed table, hand sequences and random
// traffic, all compared against a behavioural model of the arbitration rules.
module tb_dmem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic          clk, rst_n;
  logic          p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic [3:0]    p0_wstrb, p1_wstrb;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wstrb(p0_wstrb), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wstrb(p1_wstrb), .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: synchronous, one-cycle read latency, driven by the DUT
  logic [31:0] env_mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= env_mem[mem_addr[9:2]];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts consecutive denied cycles, remembers lock ownership
  // and which port a read returns to, with its own copy of memory.
  logic [31:0] ref_mem [256];
  int          m_denied;
  bit          m_locked;
  int          m_pend;      // 0 none, 1 port 0, 2 port 1
  logic [31:0] m_pend_data;
  bit          e0, e1, m_lock_eff;

  task automatic model_reset();
    m_denied = 0;
    m_locked = 0;
    m_pend   = 0;
  endtask

  task automatic model_eval();
    m_lock_eff = m_locked && p1_lock;
    e0 = 0;
    e1 = 0;
    if (m_lock_eff) e1 = p1_req;
    else if (m_denied >= int'(MAX_WAIT) && p1_req) e1 = 1;
    else if (p0_req) e0 = 1;
    else if (p1_req) e1 = 1;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    chk("p0_gnt", 32'(p0_gnt), 32'(e0));
    chk("p1_gnt", 32'(p1_gnt), 32'(e1));
    chk("mem_en", 32'(mem_en), 32'(e0 | e1));
    if (e0) begin
      chk("mem_we0", 32'(mem_we), 32'(p0_we));
      chk("mem_addr0", mem_addr, p0_addr);
      if (p0_we) begin
        chk("mem_wdata0", mem_wdata, p0_wdata);
        chk("mem_wstrb0", 32'(mem_wstrb), 32'(p0_wstrb));
      end
    end else if (e1) begin
      chk("mem_we1", 32'(mem_we), 32'(p1_we));
      chk("mem_addr1", mem_addr, p1_addr);
      if (p1_we) begin
        chk("mem_wdata1", mem_wdata, p1_wdata);
        chk("mem_wstrb1", 32'(mem_wstrb), 32'(p1_wstrb));
      end
    end
    chk("p0_rvalid", 32'(p0_rvalid), 32'(m_pend == 1));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(m_pend == 2));
    chk("p0_rdata", p0_rdata, (m_pend == 1) ? m_pend_data : 32'h0);
    chk("p1_rdata", p1_rdata, (m_pend == 2) ? m_pend_data : 32'h0);
  endtask

  task automatic advance();
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          we;
    @(posedge clk);
    m_pend = 0;
    if (e0 || e1) begin
      a  = e0 ? p0_addr : p1_addr;
      d  = e0 ? p0_wdata : p1_wdata;
      s  = e0 ? p0_wstrb : p1_wstrb;
      we = e0 ? p0_we : p1_we;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
        m_pend      = e0 ? 1 : 2;
        m_pend_data = ref_mem[a[9:2]];
      end
    end
    if (m_lock_eff) m_denied = 0;
    else if (p1_req && !e1) m_denied = m_denied + 1;
    else m_denied = 0;
    m_locked = m_lock_eff || (e1 && p1_lock);
    #1;
  endtask

  task automatic set_p0(input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb;
  endtask

  task automatic set_p1(input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input bit lock);
    p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb;
    p1_lock = lock;
  endtask

  typedef struct {
    bit          p0_req, p0_we;
    logic [31:0] p0_addr, p0_wdata;
    bit          p1_req, p1_we;
    logic [31:0] p1_addr, p1_wdata;
    bit          p1_lock;
    bit          g0, g1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // Contention: p0 wins 4 times, then the starved p1 gets one grant
    for (int i = 0; i < 4; i++) tbl[i] = '{1, 0, 32'd0, 32'd0, 1, 0, 32'd4, 32'd0, 0, 1, 0};
    tbl[4]  = '{1, 0, 32'd0, 32'd0, 1, 0, 32'd4, 32'd0, 0, 0, 1};
    tbl[5]  = '{1, 0, 32'd8, 32'd0, 0, 0, 32'd0, 32'd0, 0, 1, 0};
    tbl[6]  = '{0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, 0};
    // Locked burst of writes 96/100/104; p0 waits, then wins when lock drops
    tbl[7]  = '{0, 0, 32'd0, 32'd0, 1, 1, 32'd96, 32'h11, 1, 0, 1};
    tbl[8]  = '{1, 0, 32'd0, 32'd0, 1, 1, 32'd100, 32'h22, 1, 0, 1};
    tbl[9]  = '{1, 0, 32'd0, 32'd0, 1, 1, 32'd104, 32'h33, 1, 0, 1};
    tbl[10] = '{1, 0, 32'd96, 32'd0, 0, 0, 32'd0, 32'd0, 0, 1, 0};
    tbl[11] = '{0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, 0};

    for (int i = 0; i < 256; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem_rdata = '0;
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset then idle
    rst_n = 1'b0;
    #3;
    chk("rst_p0_gnt", 32'(p0_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_p0_rvalid", 32'(p0_rvalid), 0);
    chk("rst_p1_rvalid", 32'(p1_rvalid), 0);
    #19;
    rst_n = 1'b1;
    repeat (10) begin
      sample();
      chk("idle_mem_en", 32'(mem_en), 0);
      advance();
    end

    // Core only: write then read back address 100
    set_p0(1, 1, 32'd100, 32'd25, 4'hF);
    sample();
    chk("core_wr_gnt", 32'(p0_gnt), 1);
    chk("core_wr_we", 32'(mem_we), 1);
    advance();
    set_p0(1, 0, 32'd100, 32'd0, 4'h0);
    sample();
    chk("core_rd_gnt", 32'(p0_gnt), 1);
    chk("core_rd_we", 32'(mem_we), 0);
    advance();
    set_p0(0, 0, 0, 0, 0);
    sample();
    chk("core_rvalid", 32'(p0_rvalid), 1);
    chk("core_rdata", p0_rdata, 32'd25);
    chk("core_p1_rvalid", 32'(p1_rvalid), 0);
    chk("core_p1_rdata", p1_rdata, 0);
    advance();

    // Directed table
    foreach (tbl[i]) begin
      set_p0(tbl[i].p0_req, tbl[i].p0_we, tbl[i].p0_addr, tbl[i].p0_wdata, 4'hF);
      set_p1(tbl[i].p1_req, tbl[i].p1_we, tbl[i].p1_addr, tbl[i].p1_wdata, 4'hF, tbl[i].p1_lock);
      sample();
      chk($sformatf("tbl%0d_p0_gnt", i), 32'(p0_gnt), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_p1_gnt", i), 32'(p1_gnt), 32'(tbl[i].g1));
      advance();
    end

    // Alternating reads return to their own owner
    set_p0(1, 1, 32'd96, 32'd7, 4'hF);  sample(); advance();
    set_p0(1, 1, 32'd100, 32'd25, 4'hF); sample(); advance();
    set_p0(1, 0, 32'd96, 32'd0, 4'h0);
    sample();
    chk("alt_p0_gnt", 32'(p0_gnt), 1);
    advance();
    set_p0(0, 0, 0, 0, 0);
    set_p1(1, 0, 32'd100, 32'd0, 4'h0, 0);
    sample();
    chk("alt_p1_gnt", 32'(p1_gnt), 1);
    chk("alt_p0_rvalid", 32'(p0_rvalid), 1);
    chk("alt_p0_rdata", p0_rdata, 32'd7);
    chk("alt_p1_rvalid_a", 32'(p1_rvalid), 0);
    advance();
    set_p1(0, 0, 0, 0, 0, 0);
    sample();
    chk("alt_p1_rvalid", 32'(p1_rvalid), 1);
    chk("alt_p1_rdata", p1_rdata, 32'd25);
    chk("alt_p0_rvalid_b", 32'(p0_rvalid), 0);
    advance();

    // Random traffic obeying the hold-until-granted rule
    for (int c = 0; c < 3000; c++) begin
      if (!p0_req || e0) begin
        set_p0($urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1,
               {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
      end else if ($urandom_range(0, 3) == 0) begin
        p0_we = $urandom_range(0, 1) == 1;
        p0_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!p1_req || e1) begin
        set_p1($urandom_range(0, 99) < 50, $urandom_range(0, 1) == 1,
               {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, 4'($urandom_range(0, 15)),
               m_locked ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0));
      end
      sample();
      if (p0_rvalid && p1_rvalid) chk("both_rvalid", 1, 0);
      advance();
    end
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0, 0);
    repeat (2) begin sample(); advance(); end

    // Reset while a p1 read is in flight
    set_p1(1, 0, 32'd100, 32'd0, 4'h0, 0);
    sample();
    chk("rstrd_p1_gnt", 32'(p1_gnt), 1);
    #2;
    rst_n = 1'b0;
    set_p1(0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("rstrd_p1_rvalid_in_rst", 32'(p1_rvalid), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) begin
      sample();
      chk("rstrd_p1_rvalid", 32'(p1_rvalid), 0);
      advance();
    end
    // Starvation count must restart from zero after reset
    set_p0(1, 0, 32'd0, 32'd0, 4'h0);
    set_p1(1, 0, 32'd4, 32'd0, 4'h0, 0);
    for (int c = 1; c <= 6; c++) begin
      sample();
      chk($sformatf("rstrd_c%0d_p1_gnt", c), 32'(p1_gnt), 32'(c == 5));
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
